// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package core_fetch_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h00000013;
endpackage

// File: rtl/core_fetch_pc_reg.sv
// Program counter: reset load, word-aligned redirect load, +INSTR_BYTES increment.
module core_fetch_pc_reg
   import core_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_load_pc,
   input  logic                  i_inc,
   output logic [DATA_WIDTH-1:0] o_pc
);
   logic [DATA_WIDTH-1:0] r_pc;

   // Redirect outranks increment; the add wraps naturally at 2^DATA_WIDTH.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= {i_load_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (i_inc) begin
         r_pc <= r_pc + DATA_WIDTH'(INSTR_BYTES);
      end
   end

   assign o_pc = r_pc;
endmodule

// File: rtl/core_fetch_unit.sv
// Fetch stage: one outstanding imem request, valid/ready hand-off to decode.
// Define CORE_FETCH_PERF_EN to add fetch/kill performance counters.
module core_fetch_unit
   import core_fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_redirect_valid,
   input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
   output logic                   o_imem_req_valid,
   output logic [DATA_WIDTH-1:0]  o_imem_req_addr,
   input  logic                   i_imem_req_ready,
   input  logic                   i_imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
   output logic                   o_if_valid,
   output logic [DATA_WIDTH-1:0]  o_if_pc,
   output logic [INSTR_WIDTH-1:0] o_if_instr,
`ifdef CORE_FETCH_PERF_EN
   output logic [31:0]            o_perf_fetch_cnt,
   output logic [31:0]            o_perf_kill_cnt,
`endif
   input  logic                   i_id_ready
);
   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_REQ  = REQ;
   localparam logic [1:0] ST_WAIT = WAIT;
   localparam logic [1:0] ST_HOLD = HOLD;

   logic [1:0]             r_state;
   logic                   r_drop;
   logic [DATA_WIDTH-1:0]  r_if_pc;
   logic [INSTR_WIDTH-1:0] r_if_instr;
   logic [DATA_WIDTH-1:0]  w_pc;
   logic                   w_rsp_in_wait;
   logic                   w_accept;
   logic                   w_kill;

   assign w_rsp_in_wait = (r_state == ST_WAIT) && i_imem_rsp_valid;
   assign w_kill        = w_rsp_in_wait && (r_drop || i_redirect_valid);
   assign w_accept      = w_rsp_in_wait && !r_drop && !i_redirect_valid;

   core_fetch_pc_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (i_redirect_valid),
      .i_load_pc (i_redirect_pc),
      .i_inc     (w_accept),
      .o_pc      (w_pc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_drop     <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= INSTR_WIDTH'(NOP_INSTR);
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_REQ;
            ST_REQ: begin
               // A redirect coinciding with acceptance leaves a stale request in flight.
               if (i_imem_req_ready) begin
                  r_state <= ST_WAIT;
                  r_drop  <= i_redirect_valid;
               end
            end
            ST_WAIT: begin
               if (i_imem_rsp_valid) begin
                  r_drop <= 1'b0;
                  if (w_kill) begin
                     r_state <= ST_REQ;
                  end else begin
                     r_state    <= ST_HOLD;
                     r_if_pc    <= w_pc;
                     r_if_instr <= i_imem_rsp_data;
                  end
               end else if (i_redirect_valid) begin
                  r_drop <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (i_redirect_valid || i_id_ready) r_state <= ST_REQ;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef CORE_FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_kill_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_cnt <= '0;
         r_kill_cnt  <= '0;
      end else begin
         if ((r_state == ST_HOLD) && i_id_ready) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (w_kill)                             r_kill_cnt  <= r_kill_cnt + 32'd1;
      end
   end

   assign o_perf_fetch_cnt = r_fetch_cnt;
   assign o_perf_kill_cnt  = r_kill_cnt;
`endif

   assign o_imem_req_valid = (r_state == ST_REQ);
   assign o_imem_req_addr  = w_pc;
   assign o_if_valid       = (r_state == ST_HOLD);
   assign o_if_pc          = r_if_pc;
   assign o_if_instr       = r_if_instr;
endmodule

// File: tb/tb_core_fetch_unit.sv
// Directed-vector bench for core_fetch_unit with hand-computed expectations.
module tb_core_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        req_valid;
   logic [63:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        id_ready;
`ifdef CORE_FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_kill;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   core_fetch_unit #(
      .DATA_WIDTH  (64),
      .INSTR_WIDTH (32),
      .RESET_PC    (64'h1000)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_imem_req_valid (req_valid),
      .o_imem_req_addr  (req_addr),
      .i_imem_req_ready (req_ready),
      .i_imem_rsp_valid (rsp_valid),
      .i_imem_rsp_data  (rsp_data),
      .o_if_valid       (if_valid),
      .o_if_pc          (if_pc),
      .o_if_instr       (if_instr),
`ifdef CORE_FETCH_PERF_EN
      .o_perf_fetch_cnt (perf_fetch),
      .o_perf_kill_cnt  (perf_kill),
`endif
      .i_id_ready       (id_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starts in REQ; leaves the DUT in HOLD with the delivered word checked.
   task automatic fetch_to_hold(input string tag, input logic [63:0] exp_pc, input logic [31:0] data);
      req_ready = 1'b1;
      chk({tag, "_req_valid"}, 64'(req_valid), 64'd1);
      chk({tag, "_req_addr"}, req_addr, exp_pc);
      step();
      rsp_valid = 1'b1;
      rsp_data  = data;
      step();
      rsp_valid = 1'b0;
      chk({tag, "_if_valid"}, 64'(if_valid), 64'd1);
      chk({tag, "_if_pc"}, if_pc, exp_pc);
      chk({tag, "_if_instr"}, 64'(if_instr), 64'(data));
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      req_ready      = 1'b1;
      rsp_valid      = 1'b0;
      rsp_data       = 32'h0;
      id_ready       = 1'b1;
      step();
      step();
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_if_instr", 64'(if_instr), 64'h13);
      chk("rst_if_pc", if_pc, 64'h0);

      rst = 1'b0;
      chk("c1_req_valid", 64'(req_valid), 64'd0);
      step();
      chk("c2_req_valid", 64'(req_valid), 64'd1);
      chk("c2_req_addr", req_addr, 64'h1000);

      fetch_to_hold("f0", 64'h1000, 32'h00500093);
      step();
      chk("f0_next_addr", req_addr, 64'h1004);
      chk("f0_if_drop", 64'(if_valid), 64'd0);
      fetch_to_hold("f1", 64'h1004, 32'h00500093);
      step();
      chk("f1_next_addr", req_addr, 64'h1008);

      // Decode stalls for five cycles in HOLD.
      fetch_to_hold("f2", 64'h1008, 32'h00a00113);
      id_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_if_valid", 64'(if_valid), 64'd1);
         chk("stall_if_pc", if_pc, 64'h1008);
         chk("stall_if_instr", 64'(if_instr), 64'h00a00113);
         chk("stall_no_req", 64'(req_valid), 64'd0);
      end
      id_ready = 1'b1;
      step();
      chk("stall_rel_if_valid", 64'(if_valid), 64'd0);
      chk("stall_rel_req", 64'(req_valid), 64'd1);
      chk("stall_rel_addr", req_addr, 64'h100c);

      // Redirect on the accepting cycle: in-flight response must be dropped.
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2003;
      step();
      redirect_valid = 1'b0;
      chk("rdacc_wait_req", 64'(req_valid), 64'd0);
      rsp_valid = 1'b1;
      rsp_data  = 32'hdeadbeef;
      step();
      rsp_valid = 1'b0;
      chk("rdacc_if_valid", 64'(if_valid), 64'd0);
      chk("rdacc_req", 64'(req_valid), 64'd1);
      chk("rdacc_addr", req_addr, 64'h2000);
      fetch_to_hold("f3", 64'h2000, 32'h00100193);
      step();
      chk("f3_next_addr", req_addr, 64'h2004);

      // Redirect in WAIT with the response arriving the same cycle.
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      rsp_valid      = 1'b1;
      rsp_data       = 32'h0badf00d;
      step();
      redirect_valid = 1'b0;
      rsp_valid      = 1'b0;
      chk("rdwait_if_valid", 64'(if_valid), 64'd0);
      chk("rdwait_req", 64'(req_valid), 64'd1);
      chk("rdwait_addr", req_addr, 64'h3000);

      // Redirect in REQ without acceptance, then address holds while stalled.
      req_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h4001;
      step();
      redirect_valid = 1'b0;
      chk("rdreq_req", 64'(req_valid), 64'd1);
      chk("rdreq_addr", req_addr, 64'h4000);
      step();
      chk("rdreq_hold_addr", req_addr, 64'h4000);

      // Redirect in HOLD together with a decode handshake.
      fetch_to_hold("f4", 64'h4000, 32'h00200213);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h5000;
      step();
      redirect_valid = 1'b0;
      chk("rdhold_if_valid", 64'(if_valid), 64'd0);
      chk("rdhold_addr", req_addr, 64'h5000);

      // PC wrap at the top of the address space.
      req_ready      = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hffff_ffff_ffff_fffc;
      step();
      redirect_valid = 1'b0;
      chk("wrap_addr", req_addr, 64'hffff_ffff_ffff_fffc);
      fetch_to_hold("f5", 64'hffff_ffff_ffff_fffc, 32'h00300293);
      step();
      chk("wrap_next_req", 64'(req_valid), 64'd1);
      chk("wrap_next_addr", req_addr, 64'h0);
`ifdef CORE_FETCH_PERF_EN
      chk("perf_fetch", 64'(perf_fetch), 64'd6);
      chk("perf_kill", 64'(perf_kill), 64'd2);
`endif

      // Reset while a request is outstanding.
      req_ready = 1'b1;
      step();
      rst       = 1'b1;
      rsp_valid = 1'b1;
      rsp_data  = 32'h12345678;
      step();
      rsp_valid = 1'b0;
      chk("mrst_req_valid", 64'(req_valid), 64'd0);
      chk("mrst_if_valid", 64'(if_valid), 64'd0);
      chk("mrst_if_instr", 64'(if_instr), 64'h13);
`ifdef CORE_FETCH_PERF_EN
      chk("mrst_perf_fetch", 64'(perf_fetch), 64'd0);
`endif
      rst = 1'b0;
      step();
      chk("mrst_req", 64'(req_valid), 64'd1);
      chk("mrst_addr", req_addr, 64'h1000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
